// File: rtl/gf2_xor_accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gf2_xor_accum_ctrl: reduces a framed stream of two-vector beats into one   |
// | GF(2) XOR result using a shared 3-input XOR tree and a running accumulator.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module xor_tree_3_35 (
    input  logic [34:0] in_a,
    input  logic [34:0] in_b,
    input  logic [34:0] in_c,
    output logic [34:0] out_x
);
    assign out_x = in_a ^ in_b ^ in_c;
endmodule

module gf2_xor_accum_ctrl #(
    parameter int WIDTH     = 35,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [2*WIDTH-1:0] s_data,
    input  logic               s_b_en,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_overflow,
    output logic [CNT_W-1:0]   m_beats
);
    localparam logic             ST_ACC  = 1'b0;
    localparam logic             ST_OUT  = 1'b1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    logic             state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             m_overflow_q, m_overflow_d;
    logic [CNT_W-1:0] m_beats_q, m_beats_d;

    logic [WIDTH-1:0] b_masked;
    logic [WIDTH-1:0] x;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;
    logic             terminate;

    assign b_masked  = s_data[2*WIDTH-1:WIDTH] & {WIDTH{s_b_en}};
    assign cnt_inc   = beat_cnt_q + 1'b1;
    assign accept    = (state_q == ST_ACC) && s_valid;
    // A job ends on the upstream marker or on the beat that fills the budget.
    assign terminate = s_last || (cnt_inc == MAX_CNT);

    xor_tree_3_35 u_tree (
        .in_a  (acc_q),
        .in_b  (s_data[WIDTH-1:0]),
        .in_c  (b_masked),
        .out_x (x)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACC;
            acc_q        <= '0;
            beat_cnt_q   <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_overflow_q <= 1'b0;
            m_beats_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            beat_cnt_q   <= beat_cnt_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_overflow_q <= m_overflow_d;
            m_beats_q    <= m_beats_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        beat_cnt_d   = beat_cnt_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_overflow_d = m_overflow_q;
        m_beats_d    = m_beats_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (terminate) begin
                        m_data_d     = x;
                        m_beats_d    = cnt_inc;
                        m_overflow_d = !s_last;
                        m_valid_d    = 1'b1;
                        acc_d        = '0;
                        beat_cnt_d   = '0;
                        state_d      = ST_OUT;
                    end else begin
                        acc_d      = x;
                        beat_cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = ST_ACC;
                end
            end
        endcase
    end

    always_comb begin
        s_ready    = (state_q == ST_ACC);
        m_valid    = m_valid_q;
        m_data     = m_data_q;
        m_overflow = m_overflow_q;
        m_beats    = m_beats_q;
    end
endmodule
`default_nettype wire

// File: doc/gf2_xor_accum_ctrl.md
# gf2_xor_accum_ctrl

Sequencing controller that time-multiplexes one 3-input, 35-bit XOR tree (`xor_tree_3_35`) to reduce an arbitrary-length stream of 35-bit GF(2) vectors into a single XOR result. Each input beat carries up to two vectors. The tree combines them with a running accumulator, so a job of N vectors needs ceil(N/2) beats. The block sits between the PRNG term generator, which streams partial products, and the state-update register. It frames jobs with a `last` marker, enforces a maximum job length, and presents the result on a valid/ready output.

## Interface
- `WIDTH`, 35, vector width; fixed at 35 because the block instantiates `xor_tree_3_35`.
- `MAX_BEATS`, 16, maximum beats per job before forced termination; must be ≥ 1.
- `CNT_W`, 5, beat counter width; must satisfy 2^CNT_W > MAX_BEATS.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  block can accept a beat.
- `s_data`  in  2*WIDTH  [WIDTH-1:0] = vector A, [2*WIDTH-1:WIDTH] = vector B.
- `s_b_en`  in  1  1 = vector B participates; 0 = B is treated as zero.
- `s_last`  in  1  final beat of the job.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_data`  out  WIDTH  XOR of all participating vectors of the job.
- `m_overflow`  out  1  job was force-terminated at `MAX_BEATS`; valid with `m_valid`.
- `m_beats`  out  CNT_W  number of beats consumed by the job; valid with `m_valid`.

## Operation
- Two states: ACC and OUT. Reset enters ACC.
- Reset values: `acc` = 0, `beat_cnt` = 0, `m_valid` = 0, `m_data` = 0, `m_overflow` = 0, `m_beats` = 0.
- `s_ready` = 1 in ACC and 0 in OUT. It is a registered-state decode and does not depend on `m_ready`.
- Datapath:
  - tree inputs = {`acc`, A, B & {WIDTH{`s_b_en`}}}
  - `x` = tree output, purely combinational.
- A beat is accepted in ACC when `s_valid` = 1.
  - If `s_last` = 1 or `beat_cnt` + 1 = `MAX_BEATS`:
    - `m_data` ← `x`; `m_beats` ← `beat_cnt` + 1.
    - `m_overflow` ← (`s_last` = 0).
    - `acc` ← 0; `beat_cnt` ← 0; `m_valid` ← 1; go to OUT.
  - Otherwise: `acc` ← `x`; `beat_cnt` ← `beat_cnt` + 1; stay in ACC.
- In OUT:
  - `m_data`, `m_beats` and `m_overflow` hold stable while `m_valid` = 1.
  - When `m_ready` = 1: `m_valid` ← 0 and go to ACC.
  - `m_data` keeps its last value after the handshake; it is don't-care while `m_valid` = 0.
- Forced termination:
  - The beat that reaches `MAX_BEATS` is included in the result.
  - Beats arriving after the forced termination, up to and including the upstream `s_last`, are treated as a new job. Upstream is responsible for discarding results flagged with `m_overflow`.
- With `s_b_en` = 0, vector B is ignored entirely, regardless of `s_data` contents.
- A single-beat job (`s_last` = 1 on the first beat) yields A ^ B, or A alone when `s_b_en` = 0.
- `s_valid` = 0 in ACC: no state change; `acc` and `beat_cnt` hold.
- Reset mid-job or while in OUT:
  - The partial accumulation is discarded and the pending result is dropped (`m_valid` = 0).
  - The next accepted beat starts a fresh job.

## Timing
- Result latency: `m_valid` rises on the clock edge that accepts the terminating beat, i.e. the result is visible in the cycle after the last beat is presented.
- Throughput: one beat per cycle in ACC. A job of k beats occupies k + 1 cycles minimum (k beats + 1 OUT cycle with `m_ready` = 1).
- A new job's first beat can be accepted in the cycle after the `m_valid` && `m_ready` handshake.
- No combinational path from `m_ready` to `s_ready`.
- No combinational path from `s_valid` to `m_valid`.

## Test plan
- Reset check: assert `rst` for 2 cycles with random inputs → `m_valid` = 0, `s_ready` = 1, `m_data` = 0, `m_beats` = 0 immediately after reset.
- Single beat: A = 35'h1, B = 35'h3, `s_b_en` = 1, `s_last` = 1 → next cycle `m_valid` = 1, `m_data` = 35'h2, `m_beats` = 1, `m_overflow` = 0.
- Three-beat job with `m_ready` held 0 for 4 cycles:
  - beats (A, B, `s_b_en`) = (35'h1, 35'h2, 1), (35'h4, 35'h7FFFFFFFF, 0), (35'h10, 35'h20, 1, last).
  - Required: `m_data` = 35'h37, `m_beats` = 3, all outputs stable while stalled.
  - `s_ready` = 0 until the handshake and 1 in the following cycle.
- Overflow: `MAX_BEATS` = 16, 20 beats with A = 35'h1, B = 0, `s_last` only on beat 20.
  - First result: `m_overflow` = 1, `m_beats` = 16, `m_data` = 0.
  - Second result: `m_overflow` = 0, `m_beats` = 4, `m_data` = 0.
- Reset mid-job: 2 beats of A = 35'h5, then `rst` for one cycle, then single beat A = 35'h9, `s_last` = 1 → `m_data` = 35'h9, `m_beats` = 1.
- Back-to-back random jobs (≥ 1000 jobs, random `s_valid`/`m_ready` gaps) → every result matches a reference XOR model, with no lost or duplicated results.
